jt12_slot_wr: RTL and testbench

- Slot-addressed writer for a 24-slot recirculating operator stream: the write side of the per-slot serial data carried through the 24-stage delay lines.
- Holds one width-bit value per slot in a ring that advances one slot per clk_en.
- Accepts a random-access write (slot number plus data) from the register interface, waits until that slot reaches the ring head, then overwrites it.
- Presents the head value as a serial stream to the operator pipeline.

---
 rtl/jt12_slot_wr_if.sv | 26 ++
 rtl/jt12_slot_wr.sv | 124 ++++++++++++
 tb/tb_jt12_slot_wr.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/jt12_slot_wr_if.sv
// Register-side bus for jt12_slot_wr: random-access write port plus the
// optional readback port, grouped so host and writer share one bundle.
interface jt12_slot_wr_if #(
   parameter int width = 5
);
   logic             wr_req;
   logic [4:0]       wr_slot;
   logic [width-1:0] wr_data;
   logic             busy;
   logic             wr_done;
   logic             wr_err;
   logic             rd_req;
   logic [4:0]       rd_slot;
   logic [width-1:0] rd_data;
   logic             rd_valid;

   modport master (
      output wr_req, wr_slot, wr_data, rd_req, rd_slot,
      input  busy, wr_done, wr_err, rd_data, rd_valid
   );

   modport slave (
      input  wr_req, wr_slot, wr_data, rd_req, rd_slot,
      output busy, wr_done, wr_err, rd_data, rd_valid
   );
endinterface

// File: rtl/jt12_slot_wr.sv
// 24-slot recirculating ring with a slot-addressed writer; head value drives dout.
// Define JT12_SLOT_RD_EN to build the slot readback port (rd_req/rd_data/rd_valid).
module jt12_slot_wr #(
   parameter int width = 5
) (
   input  logic             rst,
   input  logic             clk,
   input  logic             clk_en,
   jt12_slot_wr_if.slave    bus,
   output logic [4:0]       slot,
   output logic [width-1:0] dout
);
   localparam logic [4:0] LAST_SLOT = 5'd23;

   logic [width-1:0] ring_q [24];
   logic [width-1:0] ring_d [24];
   logic [4:0]       slot_q, slot_d;
   logic [4:0]       pend_slot_q, pend_slot_d;
   logic [width-1:0] pend_data_q, pend_data_d;
   logic             busy_q, busy_d;
   logic             wr_done_q, wr_done_d;
   logic             wr_err_q, wr_err_d;
   logic             accept, reject, commit;

   always_comb begin
      accept = bus.wr_req && !busy_q && (bus.wr_slot <= LAST_SLOT);
      reject = bus.wr_req && !busy_q && (bus.wr_slot >  LAST_SLOT);
      // busy_q gates commit, so a request accepted while its slot is at the head waits a full turn
      commit = clk_en && busy_q && (slot_q == pend_slot_q);

      slot_d = slot_q;
      if (clk_en) slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + 5'd1;

      ring_d = ring_q;
      if (clk_en) begin
         for (int unsigned i = 0; i < 23; i++) ring_d[i] = ring_q[i+1];
         ring_d[23] = commit ? pend_data_q : ring_q[0];
      end

      pend_slot_d = pend_slot_q;
      pend_data_d = pend_data_q;
      if (accept) begin
         pend_slot_d = bus.wr_slot;
         pend_data_d = bus.wr_data;
      end

      busy_d = busy_q;
      if (accept)      busy_d = 1'b1;
      else if (commit) busy_d = 1'b0;

      wr_done_d = commit;
      wr_err_d  = reject;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ring_q      <= '{default: '0};
         slot_q      <= '0;
         pend_slot_q <= '0;
         pend_data_q <= '0;
         busy_q      <= 1'b0;
         wr_done_q   <= 1'b0;
         wr_err_q    <= 1'b0;
      end else begin
         ring_q      <= ring_d;
         slot_q      <= slot_d;
         pend_slot_q <= pend_slot_d;
         pend_data_q <= pend_data_d;
         busy_q      <= busy_d;
         wr_done_q   <= wr_done_d;
         wr_err_q    <= wr_err_d;
      end
   end

   assign slot        = slot_q;
   assign dout        = ring_q[0];
   assign bus.busy    = busy_q;
   assign bus.wr_done = wr_done_q;
   assign bus.wr_err  = wr_err_q;

`ifdef JT12_SLOT_RD_EN
   logic             rd_pend_q, rd_pend_d;
   logic [4:0]       rd_slot_q, rd_slot_d;
   logic [width-1:0] rd_data_q, rd_data_d;
   logic             rd_valid_q, rd_valid_d;
   logic             rd_accept, rd_hit;

   always_comb begin
      rd_accept = bus.rd_req && !rd_pend_q && (bus.rd_slot <= LAST_SLOT);
      rd_hit    = rd_pend_q && clk_en && (slot_q == rd_slot_q);

      rd_slot_d = rd_accept ? bus.rd_slot : rd_slot_q;
      rd_pend_d = rd_pend_q;
      if (rd_accept)   rd_pend_d = 1'b1;
      else if (rd_hit) rd_pend_d = 1'b0;

      // sampled from the head before any same-cycle commit lands at the tail
      rd_data_d  = rd_hit ? ring_q[0] : rd_data_q;
      rd_valid_d = rd_hit;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_pend_q  <= 1'b0;
         rd_slot_q  <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_pend_q  <= rd_pend_d;
         rd_slot_q  <= rd_slot_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
`else
   logic unused_rd;
   assign unused_rd    = ^{bus.rd_req, bus.rd_slot};
   assign bus.rd_data  = '0;
   assign bus.rd_valid = 1'b0;
`endif
endmodule

// File: tb/tb_jt12_slot_wr.sv
// Directed bench for jt12_slot_wr: ring sweep, commit timing, busy/reject,
// reset during a stalled write, and readback (JT12_SLOT_RD_EN builds).
module tb_jt12_slot_wr;
   logic       clk = 1'b0;
   logic       rst;
   logic       clk_en;
   logic [4:0] slot;
   logic [4:0] dout;

   jt12_slot_wr_if #(.width(5)) bus ();

   jt12_slot_wr #(.width(5)) dut (
      .rst    (rst),
      .clk    (clk),
      .clk_en (clk_en),
      .bus    (bus),
      .slot   (slot),
      .dout   (dout)
   );

   always #5 clk = ~clk;

   typedef struct { int s; int d; } wr_t;
   wr_t wq[$];
   int  mem [24];
   int  tests = 0;
   int  fails = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_slot(input int s, input string tag);
      int n = 0;
      while (slot !== 5'(s) && n < 48) begin
         step();
         n++;
      end
      chk({tag, "_reach"}, 32'(slot), 32'(s));
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (bus.wr_done !== 1'b1 && n < 60) begin
         step();
         n++;
      end
   endtask

   task automatic write(input int s, input int d, input bit push);
      bus.wr_req  = 1'b1;
      bus.wr_slot = 5'(s);
      bus.wr_data = 5'(d);
      if (push) wq.push_back('{s: s, d: d});
      step();
      bus.wr_req = 1'b0;
   endtask

   task automatic retire();
      wr_t w;
      chk("sb_nonempty", 32'(wq.size() > 0), 32'd1);
      if (wq.size() > 0) begin
         w = wq.pop_front();
         mem[w.s] = w.d;
      end
   endtask

   initial begin
      int  n;
      int  held;
      int  seen;
      rst = 1'b1; clk_en = 1'b0;
      bus.wr_req = 1'b0; bus.wr_slot = '0; bus.wr_data = '0;
      bus.rd_req = 1'b0; bus.rd_slot = '0;
      foreach (mem[i]) mem[i] = 0;
      step(); step();
      rst = 1'b0;
      chk("rst_slot", 32'(slot), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'(bus.wr_done), 0);
      chk("rst_err", 32'(bus.wr_err), 0);
      chk("rst_rdv", 32'(bus.rd_valid), 0);
      chk("rst_rdd", 32'(bus.rd_data), 0);

      clk_en = 1'b1;
      for (int i = 0; i <= 24; i++) begin
         chk("sweep_slot", 32'(slot), 32'(i % 24));
         chk("sweep_dout", 32'(dout), 0);
         chk("sweep_busy", 32'(bus.busy), 0);
         if (i < 24) step();
      end

      // Test 1: accept at slot 2 for slot 5
      wait_slot(2, "t1");
      write(5, 'h1A, 1'b1);
      chk("t1_busy", 32'(bus.busy), 1);
      wait_done(n);
      chk("t1_lat", 32'(n), 3);
      chk("t1_done_slot", 32'(slot), 6);
      chk("t1_busy_clr", 32'(bus.busy), 0);
      retire();
      step();
      chk("t1_done_pulse", 32'(bus.wr_done), 0);
      wait_slot(5, "t1b");
      chk("t1_dout", 32'(dout), 32'h1A);
      repeat (24) step();
      chk("t1_slot_rev", 32'(slot), 5);
      chk("t1_dout_rev", 32'(dout), 32'h1A);

      // Test 2: accept while the target slot is already at the head
      wait_slot(7, "t2");
      write(7, 'h03, 1'b1);
      n = 0; held = 1;
      while (bus.wr_done !== 1'b1 && n < 60) begin
         if (bus.busy !== 1'b1) held = 0;
         step();
         n++;
      end
      chk("t2_lat", 32'(n), 24);
      chk("t2_busy_held", 32'(held), 1);
      chk("t2_done_slot", 32'(slot), 8);
      retire();
      wait_slot(7, "t2b");
      chk("t2_dout", 32'(dout), 32'h03);

      // Test 3: request while busy is dropped; slot 24 is rejected
      wait_slot(10, "t3");
      write(12, 'h15, 1'b1);
      write(9, 'h11, 1'b0);
      chk("t3_noerr_busy", 32'(bus.wr_err), 0);
      wait_done(n);
      chk("t3_lat", 32'(n), 1);
      chk("t3_done_slot", 32'(slot), 13);
      retire();
      write(24, 'h1F, 1'b0);
      chk("t3_err", 32'(bus.wr_err), 1);
      chk("t3_err_busy", 32'(bus.busy), 0);
      step();
      chk("t3_err_pulse", 32'(bus.wr_err), 0);
      chk("t3_err_busy2", 32'(bus.busy), 0);
      wait_slot(0, "t3b");
      for (int i = 0; i < 24; i++) begin
         chk("t3_sweep_slot", 32'(slot), 32'(i));
         chk("t3_sweep_dout", 32'(dout), 32'(mem[i]));
         step();
      end

      // Test 4: stalled write to slot 20, then reset
      wait_slot(14, "t4");
      clk_en = 1'b0;
      write(20, 'h1F, 1'b0);
      chk("t4_busy", 32'(bus.busy), 1);
      seen = 0;
      repeat (50) begin
         step();
         if (bus.wr_done === 1'b1) seen = 1;
      end
      chk("t4_stall_busy", 32'(bus.busy), 1);
      chk("t4_stall_nodone", 32'(seen), 0);
      chk("t4_stall_slot", 32'(slot), 14);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t4_rst_busy", 32'(bus.busy), 0);
      chk("t4_rst_slot", 32'(slot), 0);
      chk("t4_rst_done", 32'(bus.wr_done), 0);
      foreach (mem[i]) mem[i] = 0;
      clk_en = 1'b1;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         chk("t4_sweep_slot", 32'(slot), 32'(i % 24));
         chk("t4_sweep_dout", 32'(dout), 0);
         if (bus.wr_done === 1'b1) seen = 1;
         step();
      end
      chk("t4_nodone", 32'(seen), 0);

      // Test 5: readback of slot 3
      wait_slot(1, "t5");
      write(3, 'h0C, 1'b1);
      wait_done(n);
      chk("t5_lat", 32'(n), 2);
      retire();
      bus.rd_req  = 1'b1;
      bus.rd_slot = 5'd3;
      step();
      bus.rd_req  = 1'b0;
      n = 0;
      while (bus.rd_valid !== 1'b1 && n < 60) begin
         step();
         n++;
      end
`ifdef JT12_SLOT_RD_EN
      chk("t5_rd_lat", 32'(n), 23);
      chk("t5_rd_valid", 32'(bus.rd_valid), 1);
      chk("t5_rd_data", 32'(bus.rd_data), 32'(mem[3]));
      step();
      chk("t5_rd_pulse", 32'(bus.rd_valid), 0);
`else
      chk("t5_rd_valid_off", 32'(bus.rd_valid), 0);
      chk("t5_rd_data_off", 32'(bus.rd_data), 0);
`endif
      chk("sb_empty", 32'(wq.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
